// File: rtl/packet_deframer_if.sv
// Byte-stream bus for the packet deframer: upstream FIFO pop side and downstream valid/ready side.
// master is the deframer's view, slave is the view of the FIFO and sink around it.
interface packet_deframer_if;
    logic [7:0] fifo_data;
    logic       fifo_empty;
    logic       fifo_read_enable;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       out_err;

    modport master (
        input  fifo_data,
        input  fifo_empty,
        output fifo_read_enable,
        output out_data,
        output out_valid,
        input  out_ready,
        output out_last,
        output out_err
    );

    modport slave (
        output fifo_data,
        output fifo_empty,
        input  fifo_read_enable,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  out_last,
        input  out_err
    );
endinterface

// File: rtl/packet_deframer.sv
// HDLC-style byte-stuffed frame decoder: strips 0x7E flags and 0x7D escapes from a FIFO byte stream
// and emits payload bytes with last/err marking, holding one byte back to tag the frame end.
module packet_deframer #(
    parameter int unsigned MAX_LEN = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    packet_deframer_if.master    bus,
    output logic                 frame_error,
    output logic [7:0]           error_count
);

    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);
    localparam logic [7:0]  FLAG    = 8'h7E;
    localparam logic [7:0]  ESC_B   = 8'h7D;
    localparam logic [7:0]  ESC_XOR = 8'h20;

    typedef enum logic [1:0] {HUNT, IDLE, DATA, ESC} state_t;

    state_t           state;
    logic             hold_valid;
    logic [7:0]       hold_data;
    logic [LEN_W-1:0] len;

    logic             out_free;
    logic             pop;
    logic             is_data;
    logic [7:0]       dec_byte;

    // Pop whenever a byte is available and the output slot can absorb a possible emit.
    assign out_free             = !bus.out_valid || bus.out_ready;
    assign pop                  = !reset && !bus.fifo_empty && out_free;
    assign bus.fifo_read_enable = pop;

    // Classify the head byte: payload bytes (after unescaping) share one update path.
    always_comb begin
        is_data  = 1'b0;
        dec_byte = bus.fifo_data;
        case (state)
            IDLE, DATA: is_data = (bus.fifo_data != FLAG) && (bus.fifo_data != ESC_B);
            ESC: begin
                is_data  = (bus.fifo_data != FLAG);
                dec_byte = bus.fifo_data ^ ESC_XOR;
            end
            default: is_data = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= HUNT;
            hold_valid    <= 1'b0;
            hold_data     <= 8'h00;
            len           <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= 8'h00;
            bus.out_last  <= 1'b0;
            bus.out_err   <= 1'b0;
            frame_error   <= 1'b0;
            error_count   <= 8'h00;
        end else begin
            frame_error <= 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end

            if (pop) begin
                if (is_data) begin
                    if (len < LEN_W'(MAX_LEN)) begin
                        if (hold_valid) begin
                            bus.out_data  <= hold_data;
                            bus.out_last  <= 1'b0;
                            bus.out_err   <= 1'b0;
                            bus.out_valid <= 1'b1;
                        end
                        hold_data  <= dec_byte;
                        hold_valid <= 1'b1;
                        len        <= len + LEN_W'(1);
                        state      <= DATA;
                    end else begin
                        // Overflow: close the frame as errored and drop bytes until the next flag.
                        if (hold_valid) begin
                            bus.out_data  <= hold_data;
                            bus.out_last  <= 1'b1;
                            bus.out_err   <= 1'b1;
                            bus.out_valid <= 1'b1;
                        end
                        frame_error <= 1'b1;
                        if (error_count != 8'hFF) begin
                            error_count <= error_count + 8'd1;
                        end
                        hold_valid <= 1'b0;
                        len        <= '0;
                        state      <= HUNT;
                    end
                end else begin
                    case (state)
                        HUNT: begin
                            if (bus.fifo_data == FLAG) begin
                                state <= IDLE;
                            end
                        end
                        IDLE: begin
                            if (bus.fifo_data == ESC_B) begin
                                state <= ESC;
                            end
                        end
                        DATA: begin
                            if (bus.fifo_data == FLAG) begin
                                if (hold_valid) begin
                                    bus.out_data  <= hold_data;
                                    bus.out_last  <= 1'b1;
                                    bus.out_err   <= 1'b0;
                                    bus.out_valid <= 1'b1;
                                end
                                hold_valid <= 1'b0;
                                len        <= '0;
                                state      <= IDLE;
                            end else begin
                                state <= ESC;
                            end
                        end
                        ESC: begin
                            // Flag after escape aborts the frame; the flag itself opens the next one.
                            if (hold_valid) begin
                                bus.out_data  <= hold_data;
                                bus.out_last  <= 1'b1;
                                bus.out_err   <= 1'b1;
                                bus.out_valid <= 1'b1;
                            end
                            frame_error <= 1'b1;
                            if (error_count != 8'hFF) begin
                                error_count <= error_count + 8'd1;
                            end
                            hold_valid <= 1'b0;
                            len        <= '0;
                            state      <= IDLE;
                        end
                        default: state <= HUNT;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_packet_deframer.sv
// Directed bench for packet_deframer: FIFO and sink models driven on the falling edge,
// decoded beats compared against hand-computed {err,last,data} values.
module tb_packet_deframer;

    logic       clk;
    logic       reset;
    logic       frame_error_a, frame_error_b;
    logic [7:0] error_count_a, error_count_b;

    packet_deframer_if fa();
    packet_deframer_if fb();

    packet_deframer #(.MAX_LEN(64)) dut_a (
        .clk(clk), .reset(reset), .bus(fa),
        .frame_error(frame_error_a), .error_count(error_count_a)
    );

    packet_deframer #(.MAX_LEN(4)) dut_b (
        .clk(clk), .reset(reset), .bus(fb),
        .frame_error(frame_error_b), .error_count(error_count_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [9:0] ra[$];
    logic [9:0] rb[$];
    logic       rdy;
    logic       pend_a, pend_b;
    int         fe_a, fe_b;
    int         cyc, pops_a, first_pop_a, last_pop_a;
    int         n_checks, n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] beat_a(input int i);
        return (i < ra.size()) ? 32'(ra[i]) : 32'hDEAD;
    endfunction

    function automatic logic [31:0] beat_b(input int i);
        return (i < rb.size()) ? 32'(rb[i]) : 32'hDEAD;
    endfunction

    // Record what the next rising edge will do: pops and accepted beats.
    task automatic sample();
        pend_a = fa.fifo_read_enable;
        pend_b = fb.fifo_read_enable;
        if (pend_a) begin
            if (pops_a == 0) first_pop_a = cyc;
            last_pop_a = cyc;
            pops_a++;
        end
        if (fa.out_valid && rdy) ra.push_back({fa.out_err, fa.out_last, fa.out_data});
        if (fb.out_valid && rdy) rb.push_back({fb.out_err, fb.out_last, fb.out_data});
        if (frame_error_a) fe_a++;
        if (frame_error_b) fe_b++;
    endtask

    task automatic cycle();
        @(negedge clk);
        if (pend_a) void'(qa.pop_front());
        if (pend_b) void'(qb.pop_front());
        fa.fifo_empty = (qa.size() == 0);
        fa.fifo_data  = (qa.size() != 0) ? qa[0] : 8'h00;
        fb.fifo_empty = (qb.size() == 0);
        fb.fifo_data  = (qb.size() != 0) ? qb[0] : 8'h00;
        fa.out_ready  = rdy;
        fb.out_ready  = rdy;
        cyc++;
        #1;
        sample();
    endtask

    task automatic drain(input int max_cycles);
        int idle = 0;
        for (int i = 0; i < max_cycles && idle < 3; i++) begin
            cycle();
            if (qa.size() == 0 && qb.size() == 0 && !pend_a && !pend_b) idle++;
            else idle = 0;
        end
        if (idle < 3) check("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_valid_a(input int max_cycles);
        int i = 0;
        while (!fa.out_valid && i < max_cycles) begin
            cycle();
            i++;
        end
        if (!fa.out_valid) check("valid_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int fe0, rb0;
        n_checks = 0; n_fail = 0; cyc = 0; pops_a = 0; first_pop_a = 0; last_pop_a = 0;
        fe_a = 0; fe_b = 0; pend_a = 1'b0; pend_b = 1'b0;
        fa.fifo_empty = 1'b1; fa.fifo_data = 8'h00; fa.out_ready = 1'b1;
        fb.fifo_empty = 1'b1; fb.fifo_data = 8'h00; fb.out_ready = 1'b1;
        rdy   = 1'b1;
        reset = 1'b1;

        // Reset with a non-empty FIFO: nothing may be popped.
        qa = '{8'h41, 8'h7E, 8'h01, 8'h02, 8'h03, 8'h7E};
        repeat (3) cycle();
        check("rst_ren", 32'(fa.fifo_read_enable), 32'd0);
        check("rst_valid", 32'(fa.out_valid), 32'd0);
        check("rst_data", 32'(fa.out_data), 32'd0);
        check("rst_last_err", 32'({fa.out_last, fa.out_err}), 32'd0);
        check("rst_fe", 32'(frame_error_a), 32'd0);
        check("rst_ec", 32'(error_count_a), 32'd0);
        check("rst_qa", 32'(qa.size()), 32'd6);

        // Basic frame with leading garbage, full-rate popping.
        reset = 1'b0;
        #1;
        sample();
        drain(60);
        check("basic_n", 32'(ra.size()), 32'd3);
        check("basic_b0", beat_a(0), 32'h001);
        check("basic_b1", beat_a(1), 32'h002);
        check("basic_b2", beat_a(2), 32'h103);
        check("basic_pops", 32'(pops_a), 32'd6);
        check("basic_rate", 32'(last_pop_a - first_pop_a), 32'd5);
        check("basic_ec", 32'(error_count_a), 32'd0);

        // Escaped flag and escape bytes.
        ra.delete();
        qa = '{8'h7E, 8'h7D, 8'h5E, 8'h7D, 8'h5D, 8'h7E};
        drain(60);
        check("esc_n", 32'(ra.size()), 32'd2);
        check("esc_b0", beat_a(0), 32'h07E);
        check("esc_b1", beat_a(1), 32'h17D);
        check("esc_ec", 32'(error_count_a), 32'd0);

        // Abort via escape+flag, then a clean frame.
        ra.delete();
        fe0 = fe_a;
        qa = '{8'h7E, 8'h11, 8'h22, 8'h7D, 8'h7E, 8'h33, 8'h7E};
        drain(60);
        check("abort_n", 32'(ra.size()), 32'd3);
        check("abort_b0", beat_a(0), 32'h011);
        check("abort_b1", beat_a(1), 32'h322);
        check("abort_b2", beat_a(2), 32'h133);
        check("abort_fe", 32'(fe_a - fe0), 32'd1);
        check("abort_ec", 32'(error_count_a), 32'd1);

        // Overflow on the MAX_LEN=4 instance.
        qb = '{8'h7E, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h7E, 8'h7E, 8'h09, 8'h7E};
        drain(80);
        check("ovf_n", 32'(rb.size()), 32'd5);
        check("ovf_b0", beat_b(0), 32'h001);
        check("ovf_b1", beat_b(1), 32'h002);
        check("ovf_b2", beat_b(2), 32'h003);
        check("ovf_b3", beat_b(3), 32'h304);
        check("ovf_b4", beat_b(4), 32'h109);
        check("ovf_ec", 32'(error_count_b), 32'd1);

        // Repeated empty aborts drive the error counter into saturation.
        fe0 = fe_b;
        rb0 = rb.size();
        for (int i = 0; i < 260; i++) begin
            qb.push_back(8'h7D);
            qb.push_back(8'h7E);
        end
        drain(1200);
        check("sat_ec", 32'(error_count_b), 32'd255);
        check("sat_fe", 32'(fe_b - fe0), 32'd260);
        check("sat_nobeat", 32'(rb.size()), 32'(rb0));

        // Downstream stall: no pops, output held, nothing lost after release.
        ra.delete();
        rdy = 1'b0;
        qa = '{8'h7E, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h7E};
        wait_valid_a(20);
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("stall_ren", 32'(fa.fifo_read_enable), 32'd0);
            check("stall_data", 32'({fa.out_valid, fa.out_data}), 32'h1A0);
        end
        check("stall_left", 32'(qa.size()), 32'd3);
        rdy = 1'b1;
        drain(60);
        check("stall_n", 32'(ra.size()), 32'd4);
        check("stall_b0", beat_a(0), 32'h0A0);
        check("stall_b1", beat_a(1), 32'h0A1);
        check("stall_b2", beat_a(2), 32'h0A2);
        check("stall_b3", beat_a(3), 32'h1A3);

        // Asynchronous reset while a beat is pending, then resync on the next flag.
        ra.delete();
        rdy = 1'b0;
        qa = '{8'h7E, 8'h55, 8'h66, 8'h77, 8'h7E};
        wait_valid_a(20);
        reset = 1'b1;
        #1;
        check("arst_valid", 32'(fa.out_valid), 32'd0);
        check("arst_ren", 32'(fa.fifo_read_enable), 32'd0);
        check("arst_ec", 32'(error_count_a), 32'd0);
        pend_a = 1'b0;
        repeat (2) cycle();
        qa = '{8'h55, 8'h7E, 8'hAA, 8'h7E};
        ra.delete();
        rdy = 1'b1;
        reset = 1'b0;
        #1;
        sample();
        drain(60);
        check("arst_n", 32'(ra.size()), 32'd1);
        check("arst_b0", beat_a(0), 32'h1AA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
